div_result_stage: RTL and testbench
===================================

Name: div_result_stage

Overview:
- Downstream stage of the 32-bit combinational magnitude divider; consumes its 64-bit {remainder, quotient} result.
- Waits a programmable settle time, then captures the result and applies signed-division sign correction.
- Writes the HI (remainder) and LO (quotient) registers and reports completion and divide-by-zero to the control unit.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after start before sampling div_z (divider ripple depth); legal range 1..15.

Ports:
- clk  in  1  clock, rising-edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- op_signed  in  1  1 = DIV (signed), 0 = unsigned; latched at start.
- dividend_neg  in  1  sign of the original dividend; latched at start.
- divisor_neg  in  1  sign of the original divisor; latched at start.
- divisor_zero  in  1  divisor magnitude is zero; latched at start.
- div_z  in  64  divider output, [63:32] remainder magnitude, [31:0] quotient magnitude.
- hi_q  out  32  HI register (remainder).
- lo_q  out  32  LO register (quotient).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- dz  out  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset (clr=1 at an edge, any state): state=IDLE, hi_q=0, lo_q=0, busy=0, done=0, dz=0, settle counter=0. Reset wins over every other event.
- Every output is registered.
- States: IDLE, SETTLE, CAPTURE, FIX, WRITE, ABORT.
- IDLE, start=1 at edge E0:
  - Latch op_signed, dividend_neg, divisor_neg, divisor_zero; clear dz; busy=1.
  - If divisor_zero=1, go to ABORT.
  - Otherwise go to SETTLE with counter=SETTLE_CYCLES-1.
- SETTLE: decrement the counter each edge; when counter=0, go to CAPTURE. Total SETTLE_CYCLES cycles.
- CAPTURE: internal rem<=div_z[63:32], quo<=div_z[31:0]; go to FIX.
- FIX: only when latched op_signed=1:
  - quo<=-quo (two's complement, mod 2^32) if dividend_neg^divisor_neg.
  - rem<=-rem if dividend_neg; the remainder takes the dividend's sign.
  - Go to WRITE.
- WRITE, at the exit edge: hi_q<=rem, lo_q<=quo, done<=1, busy<=0; go to IDLE.
- ABORT, at the exit edge: hi_q/lo_q unchanged, dz<=1, done<=1, busy<=0; go to IDLE.
- Latency:
  - Normal path: done high in the cycle after edge E0+SETTLE_CYCLES+3 (E5 at default).
  - Divide-by-zero path: done high after edge E1.
  - hi_q/lo_q already hold the new values whenever done=1.
- done is high exactly one cycle. dz holds until the next accepted start or clr.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle done=1 is accepted, since the FSM is in IDLE.
- div_z is sampled only in CAPTURE; changes on div_z in other states have no effect.
- Negating 0 yields 0.
- Negating 0x80000000 yields 0x80000000 (wrap, no flag).

Optional Feature:
- Macro DIV_RESULT_STATS_EN.
- When defined:
  - Adds output op_count[15:0], counting completed normal-path operations.
  - Adds output dz_count[15:0], counting ABORT completions.
  - Both increment on the edge that asserts done, wrap at 0xFFFF->0, and clear on clr.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Unsigned 100/7, SETTLE_CYCLES=2: start at E0, op_signed=0, div_z={32'd2,32'd14} -> done=1 after E5, lo_q=14, hi_q=2, dz=0, busy high E0..E5.
- Signed -100/7: op_signed=1, dividend_neg=1, divisor_neg=0, div_z={2,14} -> lo_q=0xFFFFFFF2, hi_q=0xFFFFFFFE.
- Signed 100/-7: dividend_neg=0, divisor_neg=1 -> lo_q=0xFFFFFFF2, hi_q=0x00000002.
- Divide-by-zero, HI/LO preloaded 2/14:
  - Start with divisor_zero=1 -> done and dz=1 after E1, hi_q=2, lo_q=14 unchanged.
  - Next valid start clears dz at its E0.
- Busy and reset:
  - start pulsed at E2 during an operation -> ignored; exactly one done pulse results.
  - clr at E3 -> after E3 state IDLE, hi_q=lo_q=0, busy=0, no done.
- Stats, with DIV_RESULT_STATS_EN: 3 normal ops + 1 divide-by-zero -> op_count=3, dz_count=1; clr -> both 0.

Source files
------------

// File: rtl/div_result_stage_if.sv
// Handshake/result bundle between the control unit (master) and the divider result stage (slave).
interface div_result_stage_if;
  logic        start;
  logic        op_signed;
  logic        dividend_neg;
  logic        divisor_neg;
  logic        divisor_zero;
  logic [63:0] div_z;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy;
  logic        done;
  logic        dz;

  modport master (
    output start, op_signed, dividend_neg, divisor_neg, divisor_zero, div_z,
    input  hi_q, lo_q, busy, done, dz
  );

  modport slave (
    input  start, op_signed, dividend_neg, divisor_neg, divisor_zero, div_z,
    output hi_q, lo_q, busy, done, dz
  );
endinterface

// File: rtl/div_result_stage.sv
// Result stage of the magnitude divider: waits for ripple settle, captures {rem,quo},
// applies signed correction and writes HI/LO. Optional stats counters via DIV_RESULT_STATS_EN.
module div_result_stage #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  div_result_stage_if.slave bus
`ifdef DIV_RESULT_STATS_EN
  ,
  output logic [15:0]       op_count,
  output logic [15:0]       dz_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    FIX,
    WRITE,
    ABORT
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] rem, rem_n;
  logic [31:0] quo, quo_n;
  logic [31:0] hi_r, hi_n;
  logic [31:0] lo_r, lo_n;
  logic        busy_r, busy_n;
  logic        done_r, done_n;
  logic        dz_r, dz_n;
  logic        sgn, sgn_n;
  logic        dneg, dneg_n;
  logic        vneg, vneg_n;
  logic        zero_l, zero_n;

  assign bus.hi_q = hi_r;
  assign bus.lo_q = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dz   = dz_r;

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      sgn    <= 1'b0;
      dneg   <= 1'b0;
      vneg   <= 1'b0;
      zero_l <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      quo    <= quo_n;
      hi_r   <= hi_n;
      lo_r   <= lo_n;
      busy_r <= busy_n;
      done_r <= done_n;
      dz_r   <= dz_n;
      sgn    <= sgn_n;
      dneg   <= dneg_n;
      vneg   <= vneg_n;
      zero_l <= zero_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    quo_n   = quo;
    hi_n    = hi_r;
    lo_n    = lo_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    dz_n    = dz_r;
    sgn_n   = sgn;
    dneg_n  = dneg;
    vneg_n  = vneg;
    zero_n  = zero_l;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sgn_n  = bus.op_signed;
          dneg_n = bus.dividend_neg;
          vneg_n = bus.divisor_neg;
          zero_n = bus.divisor_zero;
          dz_n   = 1'b0;
          busy_n = 1'b1;
          if (bus.divisor_zero) begin
            state_n = ABORT;
          end else begin
            state_n = SETTLE;
            cnt_n   = CNT_INIT;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) state_n = CAPTURE;
        else           cnt_n   = cnt - 4'd1;
      end
      CAPTURE: begin
        rem_n   = bus.div_z[63:32];
        quo_n   = bus.div_z[31:0];
        state_n = FIX;
      end
      FIX: begin
        // Remainder follows the dividend's sign; -0x80000000 wraps to itself.
        if (sgn) begin
          if (dneg ^ vneg) quo_n = -quo;
          if (dneg)        rem_n = -rem;
        end
        state_n = WRITE;
      end
      WRITE: begin
        hi_n    = rem;
        lo_n    = quo;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      ABORT: begin
        dz_n    = zero_l;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DIV_RESULT_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      op_count <= '0;
      dz_count <= '0;
    end else begin
      if (state == WRITE) op_count <= op_count + 16'd1;
      if (state == ABORT) dz_count <= dz_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_result_stage.sv
// Directed self-checking bench for div_result_stage (default SETTLE_CYCLES=2).
module tb_div_result_stage;
  localparam int unsigned SC = 2;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_result_stage_if bus ();

`ifdef DIV_RESULT_STATS_EN
  logic [15:0] op_count;
  logic [15:0] dz_count;
  int          exp_opc = 0;
  int          exp_dzc = 0;
`endif

  div_result_stage #(.SETTLE_CYCLES(SC)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
`ifdef DIV_RESULT_STATS_EN
    ,
    .op_count (op_count),
    .dz_count (dz_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // div_z carries a decoy value except on the cycle before the capture edge.
  task automatic do_op(input string tag, input bit b2b, input bit sgn, input bit dn,
                       input bit vn, input bit zero, input logic [31:0] rem,
                       input logic [31:0] quo, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int lat;
    if (!b2b) begin
      @(negedge clk);
      check({tag, "/prev_done_low"}, bus.done, 0);
    end
    bus.start        = 1'b1;
    bus.op_signed    = sgn;
    bus.dividend_neg = dn;
    bus.divisor_neg  = vn;
    bus.divisor_zero = zero;
    bus.div_z        = ~{rem, quo};
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "/busy_n1"}, bus.busy, 1);
        check({tag, "/dz_clr_n1"}, bus.dz, 0);
        check({tag, "/done_n1"}, bus.done, 0);
      end
      if (i == int'(SC) + 1) bus.div_z = {rem, quo};
      if (i == int'(SC) + 2) bus.div_z = ~{rem, quo};
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({tag, "/latency"}, 64'(lat), zero ? 64'd2 : 64'(SC + 4));
    check({tag, "/hi"}, bus.hi_q, exp_hi);
    check({tag, "/lo"}, bus.lo_q, exp_lo);
    check({tag, "/dz"}, bus.dz, zero);
    check({tag, "/busy_done"}, bus.busy, 0);
`ifdef DIV_RESULT_STATS_EN
    if (lat != 0) begin
      if (zero) exp_dzc++;
      else      exp_opc++;
    end
`endif
  endtask

  initial begin
    int ndone;
    clr              = 1'b1;
    bus.start        = 1'b0;
    bus.op_signed    = 1'b0;
    bus.dividend_neg = 1'b0;
    bus.divisor_neg  = 1'b0;
    bus.divisor_zero = 1'b0;
    bus.div_z        = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("rst/hi", bus.hi_q, 0);
    check("rst/lo", bus.lo_q, 0);
    check("rst/busy", bus.busy, 0);
    check("rst/done", bus.done, 0);
    check("rst/dz", bus.dz, 0);

    do_op("udiv",    0, 0, 0, 0, 0, 32'd2, 32'd14, 32'd2, 32'd14);
    do_op("sdiv_nd", 0, 1, 1, 0, 0, 32'd2, 32'd14, 32'hFFFFFFFE, 32'hFFFFFFF2);
    do_op("sdiv_dn", 0, 1, 0, 1, 0, 32'd2, 32'd14, 32'd2, 32'hFFFFFFF2);
    do_op("sdiv_nn_b2b", 1, 1, 1, 1, 0, 32'd2, 32'd14, 32'hFFFFFFFE, 32'd14);
    do_op("unsigned_flags", 0, 0, 1, 0, 0, 32'd2, 32'd14, 32'd2, 32'd14);
    do_op("neg_zero", 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0);
    do_op("wrap", 0, 1, 0, 1, 0, 32'd1, 32'h80000000, 32'd1, 32'h80000000);
    do_op("preload", 0, 0, 0, 0, 0, 32'd2, 32'd14, 32'd2, 32'd14);
    do_op("divzero", 0, 0, 0, 0, 1, 32'd7, 32'd9, 32'd2, 32'd14);
    repeat (3) @(negedge clk);
    check("dz_hold", bus.dz, 1);
    do_op("after_dz", 0, 0, 0, 0, 0, 32'd5, 32'd6, 32'd5, 32'd6);

    // start pulsed mid-operation (with divide-by-zero set) must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op_signed = 1'b0; bus.dividend_neg = 1'b0;
    bus.divisor_neg = 1'b0; bus.divisor_zero = 1'b0; bus.div_z = {32'd3, 32'd4};
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.divisor_zero = 1'b1; bus.op_signed = 1'b1; bus.dividend_neg = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.divisor_zero = 1'b0; bus.op_signed = 1'b0; bus.dividend_neg = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("busy_ign/ndone", 64'(ndone), 1);
    check("busy_ign/hi", bus.hi_q, 3);
    check("busy_ign/lo", bus.lo_q, 4);
    check("busy_ign/dz", bus.dz, 0);
`ifdef DIV_RESULT_STATS_EN
    exp_opc++;
`endif

    // clr sampled at E3 aborts the operation silently
    @(negedge clk);
    bus.start = 1'b1; bus.div_z = {32'd8, 32'd8};
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("clr/hi", bus.hi_q, 0);
    check("clr/lo", bus.lo_q, 0);
    check("clr/busy", bus.busy, 0);
    check("clr/done", bus.done, 0);
`ifdef DIV_RESULT_STATS_EN
    exp_opc = 0;
    exp_dzc = 0;
`endif
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("clr/no_done", 64'(ndone), 0);

    do_op("post_clr", 0, 0, 0, 0, 0, 32'd11, 32'd12, 32'd11, 32'd12);
    do_op("divzero2", 0, 0, 0, 0, 1, 32'd0, 32'd0, 32'd11, 32'd12);

`ifdef DIV_RESULT_STATS_EN
    @(negedge clk);
    check("stats/op_count", op_count, 64'(exp_opc));
    check("stats/dz_count", dz_count, 64'(exp_dzc));
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("stats/op_clr", op_count, 0);
    check("stats/dz_clr", dz_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
